vga_bounce_pixel_gen: RTL and testbench

Pixel generator that sits directly downstream of the VGA sync/timing controller. It consumes that controller's pixel tick, display-enable, sync and x/y pixel coordinates, and animates a bouncing square inside a walled playfield. It drives registered 12-bit RGB plus re-aligned hsync/vsync to the Basys 3 VGA connector.

---
 rtl/vga_bounce_pixel_gen.sv | 170 +++++++++++++++++
 tb/tb_vga_bounce_pixel_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_bounce_pixel_gen.sv
// Bouncing-square pixel generator. It sits behind the VGA timing controller
// and drives registered RGB plus syncs delayed by one pixel tick so they stay
// aligned with the colour.
module vga_bounce_pixel_gen #(
  parameter int unsigned HD      = 640,
  parameter int unsigned VD      = 480,
  parameter int unsigned SQ_SIZE = 64,
  parameter int unsigned VEL     = 2,
  parameter int unsigned WALL_W  = 8,
  parameter logic [11:0] BG_RGB   = 12'h000,
  parameter logic [11:0] WALL_RGB = 12'hFFF
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        pause,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [7:0]  bounce_count
);

  localparam logic [10:0] Hd11   = 11'(HD);
  localparam logic [10:0] Vd11   = 11'(VD);
  localparam logic [10:0] Sq11   = 11'(SQ_SIZE);
  localparam logic [10:0] Vel11  = 11'(VEL);
  localparam logic [10:0] Wall11 = 11'(WALL_W);
  localparam logic [9:0]  Vel10  = 10'(VEL);
  localparam logic [9:0]  SqX0   = 10'((HD - SQ_SIZE) / 2);
  localparam logic [9:0]  SqY0   = 10'((VD - SQ_SIZE) / 2);
  localparam logic [9:0]  SqXMax = 10'(HD - WALL_W - SQ_SIZE);
  localparam logic [9:0]  SqYMax = 10'(VD - WALL_W - SQ_SIZE);
  localparam logic [9:0]  SqMin  = 10'(WALL_W);
  localparam logic [9:0]  VdRow  = 10'(VD);

  logic [9:0]  sq_x_q, sq_x_d, sq_y_q, sq_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic        bounce_x, bounce_y;
  logic [7:0]  bounce_count_q;
  logic        refresh_tick;
  logic [10:0] x11, y11, sqx11, sqy11;
  logic        in_wall, in_sq;
  logic [11:0] sq_rgb, pix_d;

  // Once per frame, in vertical blanking, so motion never tears the image.
  assign refresh_tick = p_tick && (x == 10'd0) && (y == VdRow);

  // Next-position and wall-bounce decision for both axes.
  always_comb begin
    sq_x_d   = sq_x_q;
    dir_x_d  = dir_x_q;
    bounce_x = 1'b0;
    if (dir_x_q) begin
      if ({1'b0, sq_x_q} + Sq11 + Vel11 > Hd11 - Wall11) begin
        sq_x_d   = SqXMax;
        dir_x_d  = 1'b0;
        bounce_x = 1'b1;
      end else begin
        sq_x_d = sq_x_q + Vel10;
      end
    end else begin
      if ({1'b0, sq_x_q} < Wall11 + Vel11) begin
        sq_x_d   = SqMin;
        dir_x_d  = 1'b1;
        bounce_x = 1'b1;
      end else begin
        sq_x_d = sq_x_q - Vel10;
      end
    end

    sq_y_d   = sq_y_q;
    dir_y_d  = dir_y_q;
    bounce_y = 1'b0;
    if (dir_y_q) begin
      if ({1'b0, sq_y_q} + Sq11 + Vel11 > Vd11 - Wall11) begin
        sq_y_d   = SqYMax;
        dir_y_d  = 1'b0;
        bounce_y = 1'b1;
      end else begin
        sq_y_d = sq_y_q + Vel10;
      end
    end else begin
      if ({1'b0, sq_y_q} < Wall11 + Vel11) begin
        sq_y_d   = SqMin;
        dir_y_d  = 1'b1;
        bounce_y = 1'b1;
      end else begin
        sq_y_d = sq_y_q - Vel10;
      end
    end
  end

  // Square state advances only on an unpaused refresh tick.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      sq_x_q         <= SqX0;
      sq_y_q         <= SqY0;
      dir_x_q        <= 1'b1;
      dir_y_q        <= 1'b1;
      bounce_count_q <= 8'd0;
    end else if (refresh_tick && !pause) begin
      sq_x_q  <= sq_x_d;
      sq_y_q  <= sq_y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      // A corner hit flags both axes but counts as one bounce.
      if (bounce_x || bounce_y) begin
        bounce_count_q <= bounce_count_q + 8'd1;
      end
    end
  end

  // Square colour cycles through an 8-entry palette per bounce.
  always_comb begin
    sq_rgb = 12'hF00;
    unique case (bounce_count_q[2:0])
      3'd0: sq_rgb = 12'hF00;
      3'd1: sq_rgb = 12'h0F0;
      3'd2: sq_rgb = 12'h00F;
      3'd3: sq_rgb = 12'hFF0;
      3'd4: sq_rgb = 12'h0FF;
      3'd5: sq_rgb = 12'hF0F;
      3'd6: sq_rgb = 12'hFFF;
      3'd7: sq_rgb = 12'hF80;
      default: sq_rgb = 12'hF00;
    endcase
  end

  // Priority pixel mux: blanking, wall, square, background.
  always_comb begin
    x11     = {1'b0, x};
    y11     = {1'b0, y};
    sqx11   = {1'b0, sq_x_q};
    sqy11   = {1'b0, sq_y_q};
    in_wall = (x11 < Wall11) || (x11 >= Hd11 - Wall11) ||
              (y11 < Wall11) || (y11 >= Vd11 - Wall11);
    in_sq   = (x11 >= sqx11) && (x11 < sqx11 + Sq11) &&
              (y11 >= sqy11) && (y11 < sqy11 + Sq11);
    if (!video_on) begin
      pix_d = 12'h000;
    end else if (in_wall) begin
      pix_d = WALL_RGB;
    end else if (in_sq) begin
      pix_d = sq_rgb;
    end else begin
      pix_d = BG_RGB;
    end
  end

  // Output registers load once per pixel tick, keeping syncs aligned with rgb.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      rgb       <= 12'h000;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else if (p_tick) begin
      rgb       <= pix_d;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end
  end

  assign bounce_count = bounce_count_q;

endmodule

// File: tb/tb_vga_bounce_pixel_gen.sv
// Bench for vga_bounce_pixel_gen: table-driven pixel vectors through a
// scoreboard queue, plus frame sequences checked against a small motion model.
module tb_vga_bounce_pixel_gen;

  logic        clk_100MHz = 1'b0;
  logic        reset_n;
  logic        p_tick;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        pause;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic [7:0]  bounce_count;

  vga_bounce_pixel_gen dut (
    .clk_100MHz   (clk_100MHz),
    .reset_n      (reset_n),
    .p_tick       (p_tick),
    .video_on     (video_on),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .x            (x),
    .y            (y),
    .pause        (pause),
    .rgb          (rgb),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .bounce_count (bounce_count)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    logic        vo;
    logic        hs;
    logic        vs;
    logic [9:0]  px;
    logic [9:0]  py;
    logic [11:0] e_rgb;
    logic        e_hs;
    logic        e_vs;
  } vec_t;

  typedef struct {
    logic [11:0] e_rgb;
    logic        e_hs;
    logic        e_vs;
  } exp_t;

  vec_t vecs[16];
  exp_t exp_q[$];

  int n_vec  = 0;
  int n_miss = 0;

  // Motion model.
  int msx, msy, mbc;
  bit mdx, mdy;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [11:0] pal(input int bc);
    case (bc % 8)
      0: return 12'hF00;
      1: return 12'h0F0;
      2: return 12'h00F;
      3: return 12'hFF0;
      4: return 12'h0FF;
      5: return 12'hF0F;
      6: return 12'hFFF;
      default: return 12'hF80;
    endcase
  endfunction

  function automatic logic [11:0] exp_pix(input int px, input int py, input int sx,
                                          input int sy, input int bc);
    if (px < 8 || px >= 632 || py < 8 || py >= 472) return 12'hFFF;
    if (px >= sx && px < sx + 64 && py >= sy && py < sy + 64) return pal(bc);
    return 12'h000;
  endfunction

  task automatic model_reset();
    msx = 288; msy = 208; mdx = 1'b1; mdy = 1'b1; mbc = 0;
  endtask

  task automatic model_step();
    bit b;
    b = 1'b0;
    if (mdx && msx + 66 > 632) begin msx = 568; mdx = 1'b0; b = 1'b1; end
    else if (!mdx && msx < 10) begin msx = 8; mdx = 1'b1; b = 1'b1; end
    else msx = mdx ? msx + 2 : msx - 2;
    if (mdy && msy + 66 > 472) begin msy = 408; mdy = 1'b0; b = 1'b1; end
    else if (!mdy && msy < 10) begin msy = 8; mdy = 1'b1; b = 1'b1; end
    else msy = mdy ? msy + 2 : msy - 2;
    if (b) mbc = (mbc + 1) % 256;
  endtask

  // Three idle cycles then a one-cycle p_tick; returns at the following negedge.
  task automatic pulse();
    repeat (3) @(negedge clk_100MHz);
    p_tick = 1'b1;
    @(negedge clk_100MHz);
    p_tick = 1'b0;
  endtask

  task automatic probe(input string name, input logic vo, input logic hs, input logic vs,
                       input int px, input int py, input logic [11:0] e_rgb,
                       input logic e_hs, input logic e_vs);
    exp_t e;
    video_on = vo; hsync_in = hs; vsync_in = vs;
    x = 10'(px); y = 10'(py);
    e.e_rgb = e_rgb; e.e_hs = e_hs; e.e_vs = e_vs;
    exp_q.push_back(e);
    pulse();
    e = exp_q.pop_front();
    check(name, {2'b00, rgb, hsync_out, vsync_out}, {2'b00, e.e_rgb, e.e_hs, e.e_vs});
  endtask

  task automatic refresh(input bit do_pause);
    pause = do_pause;
    video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    x = 10'd0; y = 10'd480;
    pulse();
    pause = 1'b0;
    if (!do_pause) model_step();
  endtask

  // Locates the square by its corners and the background just outside it.
  task automatic check_pos(input string name, input int ex, input int ey, input int ebc);
    probe({name, "_tl"}, 1'b1, 1'b0, 1'b0, ex, ey, exp_pix(ex, ey, ex, ey, ebc), 1'b0, 1'b0);
    probe({name, "_br"}, 1'b1, 1'b0, 1'b0, ex + 63, ey + 63,
          exp_pix(ex + 63, ey + 63, ex, ey, ebc), 1'b0, 1'b0);
    probe({name, "_l"}, 1'b1, 1'b0, 1'b0, ex - 1, ey, exp_pix(ex - 1, ey, ex, ey, ebc),
          1'b0, 1'b0);
    probe({name, "_t"}, 1'b1, 1'b0, 1'b0, ex, ey - 1, exp_pix(ex, ey - 1, ex, ey, ebc),
          1'b0, 1'b0);
    probe({name, "_r"}, 1'b1, 1'b0, 1'b0, ex + 64, ey, exp_pix(ex + 64, ey, ex, ey, ebc),
          1'b0, 1'b0);
    probe({name, "_b"}, 1'b1, 1'b0, 1'b0, ex, ey + 64, exp_pix(ex, ey + 64, ex, ey, ebc),
          1'b0, 1'b0);
    check({name, "_bc"}, {8'h00, bounce_count}, 16'(ebc));
  endtask

  initial begin
    reset_n = 1'b0; p_tick = 1'b0; video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    x = 10'd0; y = 10'd0; pause = 1'b0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk_100MHz);
    check("rst_rgb", {4'h0, rgb}, 16'h0000);
    check("rst_sync", {14'h0, hsync_out, vsync_out}, 16'h0000);
    check("rst_bc", {8'h00, bounce_count}, 16'h0000);
    reset_n = 1'b1;

    // Outputs hold while no p_tick arrives.
    video_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; x = 10'd3; y = 10'd100;
    repeat (3) @(negedge clk_100MHz);
    check("hold_no_tick", {2'b00, rgb, hsync_out, vsync_out}, 16'h0000);

    // Pixel-mux vectors at sq=(288,208), bounce_count=0.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 10'd300, 10'd220, 12'hF00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 10'd3,   10'd100, 12'hFFF, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 10'd100, 10'd100, 12'h000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 10'd300, 10'd220, 12'h000, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 10'd100, 10'd100, 12'h000, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 10'd288, 10'd208, 12'hF00, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 10'd351, 10'd271, 12'hF00, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 10'd352, 10'd271, 12'h000, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 10'd287, 10'd208, 12'h000, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 10'd288, 10'd207, 12'h000, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 10'd631, 10'd100, 12'h000, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 10'd632, 10'd100, 12'hFFF, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 10'd100, 10'd7,   12'hFFF, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 10'd100, 10'd8,   12'h000, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 10'd100, 10'd472, 12'hFFF, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 10'd700, 10'd490, 12'h000, 1'b0, 1'b1};
    for (int i = 0; i < 16; i++) begin
      probe($sformatf("mux_vec%0d", i), vecs[i].vo, vecs[i].hs, vecs[i].vs,
            int'(vecs[i].px), int'(vecs[i].py), vecs[i].e_rgb, vecs[i].e_hs, vecs[i].e_vs);
    end

    // Single step.
    refresh(1'b0);
    check_pos("step1", 290, 210, 0);

    // Run to the first bounce on the bottom wall.
    for (int f = 2; f <= 102; f++) begin
      refresh(1'b0);
      check($sformatf("bc_f%0d", f), {8'h00, bounce_count}, 16'(mbc));
      if (f == 100) check_pos("f100", 488, 408, 0);
      else if (f == 101) check_pos("f101", 490, 408, 1);
      else if (f == 102) check_pos("f102", 492, 406, 1);
      else if (f % 25 == 0) check_pos($sformatf("f%0d", f), msx, msy, mbc);
    end

    // Pause freezes motion and bounce count.
    for (int i = 0; i < 10; i++) refresh(1'b1);
    check_pos("paused", 492, 406, 1);
    refresh(1'b0);
    check_pos("unpaused", 494, 404, 1);

    // Async reset mid-frame: load a non-zero pixel first, then drop reset with no edge.
    probe("pre_rst", 1'b1, 1'b1, 1'b1, msx + 1, msy + 1, pal(mbc), 1'b1, 1'b1);
    video_on = 1'b1; x = 10'd320; y = 10'd240;
    @(negedge clk_100MHz);
    #1 reset_n = 1'b0;
    #1;
    check("arst_rgb", {4'h0, rgb}, 16'h0000);
    check("arst_sync", {14'h0, hsync_out, vsync_out}, 16'h0000);
    check("arst_bc", {8'h00, bounce_count}, 16'h0000);
    @(negedge clk_100MHz);
    reset_n = 1'b1;
    model_reset();
    check_pos("post_rst", 288, 208, 0);
    refresh(1'b0);
    check_pos("post_rst_step", 290, 210, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
